calc_ctrl_param: RTL and testbench
==================================

# calc_ctrl_param

Parametrised calculator controller: a registered state machine that turns one-cycle key events into BCD operand entry, operator selection, and ALU launch/complete handshakes. It adds several behaviours the fixed 4-digit controller lacked:
- configurable digit count;
- internal operand registers;
- operator chaining and repeat-equals;
- clear while the ALU is busy;
- an error state.

It sits between the keypad decoder and the BCD ALU, and drives the display mux.

## Interface
- DIGITS, 4: operand length in BCD digits (1-8); operand width W = 4*DIGITS.
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- key_valid  in  1  one-cycle key strobe.
- key_code  in  4  0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQ, 15 C; only sampled with key_valid.
- alu_done  in  1  one-cycle ALU completion strobe.
- alu_err  in  1  qualifies alu_done: overflow or divide-by-zero.
- alu_result  in  W  BCD result, valid with alu_done.
- op_a, op_b  out  W  BCD operands to ALU.
- op_code  out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV.
- alu_start  out  1  one-cycle launch pulse.
- disp_value  out  W  value to display.
- disp_err  out  1  display error message.
- key_drop  out  1  one-cycle pulse when a key is ignored.
- state  out  3  current state code, for debug.

## Operation

**States**

IDLE=0, ENTRY_A=1, OP_SEL=2, ENTRY_B=3, EXEC=4, RESULT=5, ERROR=6.

**Internal registers**
- digit count cnt, 0..DIGITS.
- chain flag: the ALU was launched by an operator key.
- pending op: the operator saved during a chained launch.
- clear-pending flag.

**Digit entry into the active operand** (A in IDLE/ENTRY_A, B in ENTRY_B)
- operand = {operand[W-5:0], digit}; cnt+1.
- Digit 0 with cnt=0: operand stays 0, cnt stays 0.
- cnt=DIGITS: digit ignored, key_drop pulses.

**Transitions**
- IDLE: digit -> ENTRY_A. Operator -> A=0, op_code latched, OP_SEL. EQ -> key_drop.
- ENTRY_A: digit -> shift in. Operator -> latch op_code, OP_SEL. EQ -> key_drop.
- OP_SEL: operator -> replaces op_code. Digit -> B cleared, cnt=0, digit shifted in, ENTRY_B. EQ -> B=A, EXEC.
- ENTRY_B: digit -> shift in. EQ -> EXEC with chain=0. Operator -> EXEC with chain=1, new operator stored as pending op.
- EXEC: waits for alu_done. Every non-C key is dropped.
- On alu_done:
  - alu_err=1 -> ERROR.
  - Otherwise A=alu_result, disp_value=A.
  - chain=1 -> op_code=pending op, OP_SEL.
  - chain=0 -> RESULT.
- RESULT:
  - EQ -> repeat: A is the result, B and op_code unchanged, EXEC.
  - Operator -> latch op_code, OP_SEL.
  - Digit -> A cleared, cnt=0, digit shifted in, ENTRY_A.
- ERROR: disp_err=1. Every key except C is dropped.

**Clear (C)**
- In any state except EXEC: A=B=0, op_code=0, cnt=0, disp_err=0, IDLE.
- In EXEC: sets clear-pending. On alu_done the result is discarded and the clear is applied, landing in IDLE.
- alu_done with a C key in the same cycle: same as clear-pending.

**Display (disp_value)**
- A in IDLE/ENTRY_A/OP_SEL/RESULT.
- B in ENTRY_B.
- A in EXEC.
- 0 in ERROR.

## Timing
- All outputs are registered.
- A key sampled at edge N produces updated outputs after edge N.
- alu_start is high for exactly the one cycle after the EXEC-entry edge. op_a, op_b and op_code are stable from that cycle until alu_done.
- alu_done arrives no earlier than 1 cycle after alu_start.
- EXEC->RESULT/OP_SEL/ERROR/IDLE occurs on the alu_done edge. A key in that same cycle is dropped, except C.
- key_drop is a one-cycle pulse.
- Reset values: state=IDLE; op_a, op_b, disp_value=0; op_code=0; alu_start, key_drop, disp_err=0; cnt, chain, clear-pending=0.
- Reset mid-EXEC: returns to IDLE, and a later alu_done is ignored.

## Test plan
- DIGITS=4. Keys 1,2,3,4,5 -> disp_value=0x1234, key_drop on the 5th key. Then 0,0 at the start of B: leading zeros are not counted.
- Keys 1,2, ADD, 3, EQ -> alu_start once; op_a=0x0012, op_b=0x0003, op_code=0. alu_done with result 0x0015 -> RESULT, disp_value=0x0015. EQ again -> op_a=0x0015, op_b=0x0003.
- Chain: 5, MUL, 4, SUB -> EXEC with op_code=2. alu_done with result 0x0020 -> OP_SEL, op_code=1, disp_value=0x0020.
- Keys 9, DIV, 0, EQ; alu_done with alu_err=1 -> ERROR, disp_err=1. Digit -> key_drop. C -> IDLE, all outputs 0.
- C during EXEC, alu_done 3 cycles later with result 0x0042 -> IDLE, op_a=0, disp_value=0. Also C and alu_done in the same cycle -> IDLE.
- resetn low mid-ENTRY_B, asynchronous -> all outputs at reset values immediately. Then 7 -> ENTRY_A, disp_value=0x0007.

Source files
------------

// File: rtl/calc_ctrl_param.sv
// calc_ctrl_param: calculator key controller between the keypad decoder and
// the BCD ALU. It turns one-cycle key events into BCD operand entry, operator
// selection and ALU launch/complete handshakes. It also supports operator
// chaining, repeat-equals, clear while the ALU is busy, and an error state.
//
// Handshake: key_valid and alu_done are single-cycle strobes. There is no
// back-pressure. Any key the controller cannot use is reported by a
// one-cycle key_drop pulse. alu_start pulses for the first cycle in EXEC.
// op_a, op_b and op_code hold steady until the qualifying alu_done.
//
// Ports:
//   clk, resetn             clock (rising edge), async active-low reset
//   key_valid, key_code     key strobe; 0-9 digit, 10-13 ADD/SUB/MUL/DIV,
//                           14 EQ, 15 C
//   alu_done, alu_err       ALU completion strobe and its error qualifier
//   alu_result [W]          BCD result, valid with alu_done
//   op_a, op_b [W]          BCD operands to the ALU
//   op_code [2]             0 ADD, 1 SUB, 2 MUL, 3 DIV
//   alu_start               one-cycle ALU launch pulse
//   disp_value [W]          value for the display mux
//   disp_err                display error message
//   key_drop                one-cycle pulse for an ignored key
//   state [3]               current FSM state, for debug
module calc_ctrl_param #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  alu_done,
  input  logic                  alu_err,
  input  logic [4*DIGITS-1:0]   alu_result,
  output logic [4*DIGITS-1:0]   op_a,
  output logic [4*DIGITS-1:0]   op_b,
  output logic [1:0]            op_code,
  output logic                  alu_start,
  output logic [4*DIGITS-1:0]   disp_value,
  output logic                  disp_err,
  output logic                  key_drop,
  output logic [2:0]            state
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY_A = 3'd1;
  localparam logic [2:0] S_OP_SEL  = 3'd2;
  localparam logic [2:0] S_ENTRY_B = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  logic [2:0]    state_q, state_n;
  logic [W-1:0]  a_q, a_n, b_q, b_n, disp_q, disp_n;
  logic [1:0]    opc_q, opc_n, pend_q, pend_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          chain_q, chain_n, clrp_q, clrp_n;
  logic          start_q, drop_q, drop_n, derr_q;

  logic          is_digit, is_op, is_eq, is_clr;
  logic [1:0]    kop;
  logic          ent_full, ent_skip;

  // Append one BCD digit on the right; the top digit falls off.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v,
                                            input logic [3:0] d);
    logic [W+3:0] t;
    t = {v, d};
    return t[W-1:0];
  endfunction

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = (key_code == 4'd14);
  assign is_clr   = (key_code == 4'd15);
  // Codes 10..13 map to 0..3. Subtracting 10 mod 4 is the same as subtracting 2.
  assign kop      = key_code[1:0] - 2'd2;
  // The operand is full. A leading zero is not counted as a digit.
  assign ent_full = (cnt_q == CNT_MAX);
  assign ent_skip = (key_code == 4'd0) && (cnt_q == '0);

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    opc_n   = opc_q;
    pend_n  = pend_q;
    cnt_n   = cnt_q;
    chain_n = chain_q;
    clrp_n  = clrp_q;
    drop_n  = 1'b0;

    if (state_q == S_EXEC) begin
      if (alu_done) begin
        chain_n = 1'b0;
        clrp_n  = 1'b0;
        if (clrp_q || (key_valid && is_clr)) begin
          // A clear is pending, so the result is discarded.
          state_n = S_IDLE;
          a_n     = '0;
          b_n     = '0;
          opc_n   = 2'd0;
          pend_n  = 2'd0;
          cnt_n   = '0;
        end else begin
          drop_n = key_valid;
          if (alu_err) begin
            state_n = S_ERROR;
          end else begin
            a_n = alu_result;
            if (chain_q) begin
              opc_n   = pend_q;
              state_n = S_OP_SEL;
            end else begin
              state_n = S_RESULT;
            end
          end
        end
      end else if (key_valid) begin
        if (is_clr) clrp_n = 1'b1;
        else        drop_n = 1'b1;
      end
    end else if (key_valid && is_clr) begin
      state_n = S_IDLE;
      a_n     = '0;
      b_n     = '0;
      opc_n   = 2'd0;
      pend_n  = 2'd0;
      cnt_n   = '0;
      chain_n = 1'b0;
      clrp_n  = 1'b0;
    end else if (key_valid) begin
      case (state_q)
        S_IDLE, S_ENTRY_A: begin
          if (is_digit) begin
            state_n = S_ENTRY_A;
            if (ent_full) begin
              drop_n = 1'b1;
            end else if (!ent_skip) begin
              a_n   = shift_in(a_q, key_code);
              cnt_n = cnt_q + CW'(1);
            end
          end else if (is_op) begin
            if (state_q == S_IDLE) a_n = '0;
            opc_n   = kop;
            state_n = S_OP_SEL;
          end else begin
            drop_n = 1'b1;
          end
        end
        S_OP_SEL: begin
          if (is_op) begin
            opc_n = kop;
          end else if (is_digit) begin
            // Start a fresh B operand. A first digit of 0 leaves the count at 0.
            b_n     = W'(key_code);
            cnt_n   = CW'(key_code != 4'd0);
            state_n = S_ENTRY_B;
          end else begin
            b_n     = a_q;
            chain_n = 1'b0;
            state_n = S_EXEC;
          end
        end
        S_ENTRY_B: begin
          if (is_digit) begin
            if (ent_full) begin
              drop_n = 1'b1;
            end else if (!ent_skip) begin
              b_n   = shift_in(b_q, key_code);
              cnt_n = cnt_q + CW'(1);
            end
          end else if (is_op) begin
            chain_n = 1'b1;
            pend_n  = kop;
            state_n = S_EXEC;
          end else begin
            chain_n = 1'b0;
            state_n = S_EXEC;
          end
        end
        S_RESULT: begin
          if (is_eq) begin
            // Repeat-equals: the previous result is already in A.
            chain_n = 1'b0;
            state_n = S_EXEC;
          end else if (is_op) begin
            opc_n   = kop;
            state_n = S_OP_SEL;
          end else begin
            a_n     = W'(key_code);
            cnt_n   = CW'(key_code != 4'd0);
            state_n = S_ENTRY_A;
          end
        end
        S_ERROR: drop_n = 1'b1;
        default: begin
          drop_n  = 1'b1;
          state_n = S_IDLE;
        end
      endcase
    end

    case (state_n)
      S_ENTRY_B: disp_n = b_n;
      S_ERROR:   disp_n = '0;
      default:   disp_n = a_n;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      disp_q  <= '0;
      opc_q   <= 2'd0;
      pend_q  <= 2'd0;
      cnt_q   <= '0;
      chain_q <= 1'b0;
      clrp_q  <= 1'b0;
      start_q <= 1'b0;
      drop_q  <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      disp_q  <= disp_n;
      opc_q   <= opc_n;
      pend_q  <= pend_n;
      cnt_q   <= cnt_n;
      chain_q <= chain_n;
      clrp_q  <= clrp_n;
      start_q <= (state_n == S_EXEC) && (state_q != S_EXEC);
      drop_q  <= drop_n;
      derr_q  <= (state_n == S_ERROR);
    end
  end

  assign state      = state_q;
  assign op_a       = a_q;
  assign op_b       = b_q;
  assign op_code    = opc_q;
  assign alu_start  = start_q;
  assign disp_value = disp_q;
  assign disp_err   = derr_q;
  assign key_drop   = drop_q;

endmodule

// File: tb/tb_calc_ctrl_param.sv
// Directed testbench for calc_ctrl_param with DIGITS=4. Inputs change on the
// falling edge. Outputs are sampled on the falling edge that follows the
// rising edge under test.
module tb_calc_ctrl_param;

  localparam int W = 16;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_DIV = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_C   = 4'd15;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic         alu_done = 1'b0;
  logic         alu_err = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic [W-1:0] op_a, op_b, disp_value;
  logic [1:0]   op_code;
  logic         alu_start, disp_err, key_drop;
  logic [2:0]   state;

  int checks = 0;
  int errors = 0;

  calc_ctrl_param #(.DIGITS(4)) dut (
    .clk(clk), .resetn(resetn),
    .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .alu_start(alu_start),
    .disp_value(disp_value), .disp_err(disp_err), .key_drop(key_drop),
    .state(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic finish_alu(input logic [W-1:0] r, input logic e);
    @(negedge clk);
    alu_done   = 1'b1;
    alu_result = r;
    alu_err    = e;
    @(negedge clk);
    alu_done   = 1'b0;
    alu_err    = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_op_a"}, 32'(op_a), 32'd0);
    check({tag, "_op_b"}, 32'(op_b), 32'd0);
    check({tag, "_disp"}, 32'(disp_value), 32'd0);
    check({tag, "_op_code"}, 32'(op_code), 32'd0);
    check({tag, "_start"}, 32'(alu_start), 32'd0);
    check({tag, "_drop"}, 32'(key_drop), 32'd0);
    check({tag, "_err"}, 32'(disp_err), 32'd0);
  endtask

  initial begin
    tick(2);
    resetn = 1'b1;
    tick(1);
    check_all_zero("reset");

    // Digit entry into A: the operand fills at four digits.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("a_full_state", 32'(state), 32'd1);
    check("a_full_disp", 32'(disp_value), 32'h1234);
    check("a_no_drop", 32'(key_drop), 32'd0);
    press(4'd5);
    check("a_5th_drop", 32'(key_drop), 32'd1);
    check("a_5th_disp", 32'(disp_value), 32'h1234);
    tick(1);
    check("drop_one_cycle", 32'(key_drop), 32'd0);
    press(K_ADD);
    check("opsel_state", 32'(state), 32'd2);
    // Leading zeros in B are not counted as digits.
    press(4'd0); press(4'd0);
    check("b_zero_state", 32'(state), 32'd3);
    check("b_zero_val", 32'(op_b), 32'd0);
    press(4'd7); press(4'd8); press(4'd9); press(4'd1);
    check("b_lead_zero_disp", 32'(disp_value), 32'h7891);
    check("b_lead_zero_drop", 32'(key_drop), 32'd0);
    press(4'd2);
    check("b_full_drop", 32'(key_drop), 32'd1);
    press(K_C);
    check_all_zero("clr1");

    // Simple add, then repeat-equals.
    press(4'd1); press(4'd2); press(K_ADD); press(4'd3); press(K_EQ);
    check("add_state", 32'(state), 32'd4);
    check("add_start", 32'(alu_start), 32'd1);
    check("add_op_a", 32'(op_a), 32'h0012);
    check("add_op_b", 32'(op_b), 32'h0003);
    check("add_op_code", 32'(op_code), 32'd0);
    check("add_disp_exec", 32'(disp_value), 32'h0012);
    tick(1);
    check("add_start_once", 32'(alu_start), 32'd0);
    press(4'd5);
    check("exec_key_drop", 32'(key_drop), 32'd1);
    check("exec_key_op_b", 32'(op_b), 32'h0003);
    finish_alu(16'h0015, 1'b0);
    check("add_result_state", 32'(state), 32'd5);
    check("add_result_disp", 32'(disp_value), 32'h0015);
    press(K_EQ);
    check("rep_state", 32'(state), 32'd4);
    check("rep_start", 32'(alu_start), 32'd1);
    check("rep_op_a", 32'(op_a), 32'h0015);
    check("rep_op_b", 32'(op_b), 32'h0003);
    tick(1);
    finish_alu(16'h0018, 1'b0);
    check("rep_disp", 32'(disp_value), 32'h0018);
    press(K_C);
    check_all_zero("clr2");

    // Operator chaining: 5 * 4, then SUB is selected as the pending operator.
    press(4'd5); press(K_MUL); press(4'd4); press(K_SUB);
    check("chain_state", 32'(state), 32'd4);
    check("chain_op_code", 32'(op_code), 32'd2);
    check("chain_op_a", 32'(op_a), 32'h0005);
    check("chain_op_b", 32'(op_b), 32'h0004);
    check("chain_start", 32'(alu_start), 32'd1);
    tick(1);
    finish_alu(16'h0020, 1'b0);
    check("chain_done_state", 32'(state), 32'd2);
    check("chain_done_op_code", 32'(op_code), 32'd1);
    check("chain_done_disp", 32'(disp_value), 32'h0020);
    press(K_C);

    // Divide by zero leads to the error state.
    press(4'd9); press(K_DIV); press(4'd0);
    check("div_b0_state", 32'(state), 32'd3);
    press(K_EQ);
    check("div_op_code", 32'(op_code), 32'd3);
    check("div_op_b", 32'(op_b), 32'd0);
    tick(1);
    finish_alu(16'h0000, 1'b1);
    check("err_state", 32'(state), 32'd6);
    check("err_flag", 32'(disp_err), 32'd1);
    check("err_disp", 32'(disp_value), 32'd0);
    press(4'd3);
    check("err_key_drop", 32'(key_drop), 32'd1);
    check("err_stays", 32'(state), 32'd6);
    press(K_C);
    check_all_zero("clr_err");

    // Clear while the ALU is busy: the result is discarded.
    press(4'd4); press(K_ADD); press(4'd2); press(K_EQ);
    press(K_C);
    check("clrp_state", 32'(state), 32'd4);
    check("clrp_no_drop", 32'(key_drop), 32'd0);
    tick(2);
    finish_alu(16'h0042, 1'b0);
    check_all_zero("clrp_done");

    // Clear and alu_done arrive in the same cycle.
    press(4'd4); press(K_ADD); press(4'd2); press(K_EQ);
    tick(1);
    @(negedge clk);
    key_valid = 1'b1; key_code = K_C;
    alu_done = 1'b1; alu_result = 16'h0006;
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0;
    check("clr_same_state", 32'(state), 32'd0);
    check("clr_same_disp", 32'(disp_value), 32'd0);

    // Asynchronous reset in the middle of ENTRY_B.
    press(4'd3); press(K_ADD); press(4'd5);
    check("pre_rst_state", 32'(state), 32'd3);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    resetn = 1'b1;
    press(4'd7);
    check("post_rst_state", 32'(state), 32'd1);
    check("post_rst_disp", 32'(disp_value), 32'h0007);
    press(K_C);

    // Reset during EXEC: a late alu_done is ignored.
    press(4'd1); press(K_ADD); press(4'd1); press(K_EQ);
    #2 resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    finish_alu(16'h0099, 1'b0);
    check("late_done_state", 32'(state), 32'd0);
    check("late_done_disp", 32'(disp_value), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
